execute_cycle: RTL and testbench
================================

EXECUTE_CYCLE -- requirements
Module: execute_cycle
Interface
REQ-001 The block SHALL use clk (input, 1) as its only clock: rising edge, all state.
REQ-002 The block SHALL use rst (input, 1) as its reset: synchronous, active-high.
REQ-003 regwriteE  input  1  register-file write enable of the EX instruction.
REQ-004 resultsrcE  input  2  writeback source select: 00 ALU, 01 memory, 10 pc+4.
REQ-005 memwriteE  input  1  store enable.
REQ-006 branchE  input  1  instruction is beq.
REQ-007 jumpE  input  1  instruction is jal.
REQ-008 alucontrolE  input  3  ALU operation code.
REQ-009 alusrcE  input  1  ALU operand B select: 1 = immextE, 0 = register.
REQ-010 rd1E  input  32  register operand rs1.
REQ-011 rd2E  input  32  register operand rs2.
REQ-012 pcE  input  32  PC of the EX instruction.
REQ-013 immextE  input  32  sign-extended immediate.
REQ-014 pcplus4E  input  32  pcE+4.
REQ-015 rdE  input  5  destination register.
REQ-016 forwardAE  input  2  operand A forward select from the hazard unit.
REQ-017 forwardBE  input  2  operand B forward select from the hazard unit.
REQ-018 resultW  input  32  writeback-stage result for forwarding.
REQ-019 pcsrcE  output  1  redirect fetch to pctargetE; combinational.
REQ-020 pctargetE  output  32  branch/jump target; combinational.
REQ-021 regwriteM  output  1  registered regwriteE.
REQ-022 resultsrcM  output  2  registered resultsrcE.
REQ-023 memwriteM  output  1  registered memwriteE.
REQ-024 aluresultM  output  32  registered ALU result.
REQ-025 writedataM  output  32  registered forwarded operand B (store data).
REQ-026 rdM  output  5  registered rdE.
REQ-027 pcplus4M  output  32  registered pcplus4E.
Function
REQ-028 SrcA SHALL be selected by forwardAE: 00 rd1E; 01 resultW; 10 aluresultM; 11 rd1E. writedataE SHALL be selected identically by forwardBE from rd2E.
REQ-029 SrcB SHALL be immextE when alusrcE=1, else writedataE. Store data SHALL always be writedataE, never the immediate.
REQ-030 The ALU SHALL compute: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 101 signed A<B ? 1 : 0; all other codes 0. Arithmetic wraps mod 2^32, with no overflow flag.
REQ-031 zeroE SHALL be 1 exactly when the ALU result is 32'h0.
REQ-032 pcsrcE SHALL equal (branchE & zeroE) | jumpE in the same cycle. When branchE=1 and jumpE=1 together, pcsrcE SHALL be 1.
REQ-033 pctargetE SHALL equal pcE + immextE mod 2^32.
REQ-034 On each rising clk edge with rst=0, the EX/MEM register SHALL capture regwriteE, resultsrcE, memwriteE, ALU result, writedataE, rdE and pcplus4E. Latency is exactly 1 cycle; the register has no stall or enable.
REQ-035 With forward select 10, an operand SHALL use the block's own registered aluresultM, so back-to-back dependent ALU ops resolve without a bubble.
Reset
REQ-036 When rst=1 at a rising edge, all M outputs SHALL become 0, so the next cycle is a NOP bubble (regwriteM=0, memwriteM=0). rst overrides any in-flight instruction.
REQ-037 pcsrcE and pctargetE SHALL be combinational and unaffected by rst.
Configuration
REQ-038 With EX_FORWARD_EN defined, REQ-028 forwarding SHALL apply. Without it, forwardAE and forwardBE SHALL be ignored, SrcA SHALL be rd1E, writedataE SHALL be rd2E, and the ports SHALL remain present.
Verification
REQ-039 Scenario: rd1E=5, rd2E=7, alucontrolE=000, alusrcE=0, rdE=3, regwriteE=1 -> next cycle aluresultM=12, rdM=3, regwriteM=1.
REQ-040 Scenario: rd1E=32'hFFFFFFFF, immextE=1, alusrcE=1, alucontrolE=101 -> aluresultM=1 (signed -1<1). Same inputs with alucontrolE=000 -> aluresultM=0 (wrap).
REQ-041 Scenario: branchE=1, rd1E=rd2E=9, alucontrolE=001, pcE=32'h100, immextE=32'hFFFFFFF8 -> pcsrcE=1 and pctargetE=32'hF8 in the same cycle. With rd2E=8 -> pcsrcE=0.
REQ-042 Scenario: aluresultM=20, resultW=30, forwardAE=10, forwardBE=01, alucontrolE=000 -> next aluresultM=50, writedataM=30. With EX_FORWARD_EN undefined -> rd1E+rd2E instead.
REQ-043 Scenario: valid store in flight with memwriteE=1 and rst=1 at that edge -> memwriteM=0 and every M output is 0.
REQ-044 Scenario: jumpE=1, pcplus4E=32'h204, resultsrcE=10 -> pcsrcE=1 and, next cycle, pcplus4M=32'h204, resultsrcM=10.

Source files
------------

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of a 5-stage RV32 pipeline plus the EX/MEM register.
// Selects forwarded operands, runs the ALU, resolves beq/jal redirects
// combinationally and registers the results for the MEM stage.
// Optional feature: define EX_FORWARD_EN to honour forwardAE/forwardBE;
// without it operands come straight from rd1E/rd2E and the forward ports are ignored.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        regwriteE,
    input  logic [1:0]  resultsrcE,
    input  logic        memwriteE,
    input  logic        branchE,
    input  logic        jumpE,
    input  logic [2:0]  alucontrolE,
    input  logic        alusrcE,
    input  logic [31:0] rd1E,
    input  logic [31:0] rd2E,
    input  logic [31:0] pcE,
    input  logic [31:0] immextE,
    input  logic [31:0] pcplus4E,
    input  logic [4:0]  rdE,
    input  logic [1:0]  forwardAE,
    input  logic [1:0]  forwardBE,
    input  logic [31:0] resultW,
    output logic        pcsrcE,
    output logic [31:0] pctargetE,
    output logic        regwriteM,
    output logic [1:0]  resultsrcM,
    output logic        memwriteM,
    output logic [31:0] aluresultM,
    output logic [31:0] writedataM,
    output logic [4:0]  rdM,
    output logic [31:0] pcplus4M
);

    logic [31:0] w_srca;
    logic [31:0] w_writedata;
    logic [31:0] w_srcb;
    logic [31:0] w_aluresult;
    logic        w_zero;

    logic        r_regwrite;
    logic [1:0]  r_resultsrc;
    logic        r_memwrite;
    logic [31:0] r_aluresult;
    logic [31:0] r_writedata;
    logic [4:0]  r_rd;
    logic [31:0] r_pcplus4;

`ifdef EX_FORWARD_EN
    // Operand forwarding: 10 takes our own registered ALU result so dependent
    // back-to-back ALU ops need no bubble; 11 falls back to the register value.
    always_comb begin
        w_srca      = rd1E;
        w_writedata = rd2E;
        case (forwardAE)
            2'b01:   w_srca = resultW;
            2'b10:   w_srca = r_aluresult;
            default: w_srca = rd1E;
        endcase
        case (forwardBE)
            2'b01:   w_writedata = resultW;
            2'b10:   w_writedata = r_aluresult;
            default: w_writedata = rd2E;
        endcase
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{forwardAE, forwardBE, resultW};

    // Forwarding disabled: operands come directly from the register file reads.
    always_comb begin
        w_srca      = rd1E;
        w_writedata = rd2E;
    end
`endif

    // Operand B mux; store data stays the register operand regardless of alusrcE.
    always_comb begin
        w_srcb = alusrcE ? immextE : w_writedata;
    end

    // ALU: add, sub, and, or, signed set-less-than; undefined codes yield 0.
    always_comb begin
        w_aluresult = 32'h0;
        case (alucontrolE)
            3'b000:  w_aluresult = w_srca + w_srcb;
            3'b001:  w_aluresult = w_srca - w_srcb;
            3'b010:  w_aluresult = w_srca & w_srcb;
            3'b011:  w_aluresult = w_srca | w_srcb;
            3'b101:  w_aluresult = ($signed(w_srca) < $signed(w_srcb)) ? 32'h1 : 32'h0;
            default: w_aluresult = 32'h0;
        endcase
    end

    // Branch/jump resolution; purely combinational so reset never touches it.
    always_comb begin
        w_zero    = (w_aluresult == 32'h0);
        pcsrcE    = (branchE & w_zero) | jumpE;
        pctargetE = pcE + immextE;
    end

    // EX/MEM register: no stall, reset inserts a NOP bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regwrite  <= 1'b0;
            r_resultsrc <= 2'b00;
            r_memwrite  <= 1'b0;
            r_aluresult <= 32'h0;
            r_writedata <= 32'h0;
            r_rd        <= 5'h0;
            r_pcplus4   <= 32'h0;
        end else begin
            r_regwrite  <= regwriteE;
            r_resultsrc <= resultsrcE;
            r_memwrite  <= memwriteE;
            r_aluresult <= w_aluresult;
            r_writedata <= w_writedata;
            r_rd        <= rdE;
            r_pcplus4   <= pcplus4E;
        end
    end

    assign regwriteM  = r_regwrite;
    assign resultsrcM = r_resultsrc;
    assign memwriteM  = r_memwrite;
    assign aluresultM = r_aluresult;
    assign writedataM = r_writedata;
    assign rdM        = r_rd;
    assign pcplus4M   = r_pcplus4;

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed vectors for execute_cycle. Driver applies one
// instruction per cycle on the falling edge and queues the hand-computed
// EX/MEM contents; a monitor pops one entry after every rising edge.
// Interface timing: inputs change at negedge, M outputs valid #1 after posedge,
// combinational outputs valid #1 after the inputs change.
module tb_execute_cycle;

    localparam int W = 105;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwriteE;
    logic [1:0]  resultsrcE;
    logic        memwriteE;
    logic        branchE;
    logic        jumpE;
    logic [2:0]  alucontrolE;
    logic        alusrcE;
    logic [31:0] rd1E, rd2E, pcE, immextE, pcplus4E;
    logic [4:0]  rdE;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] resultW;
    logic        pcsrcE;
    logic [31:0] pctargetE;
    logic        regwriteM;
    logic [1:0]  resultsrcM;
    logic        memwriteM;
    logic [31:0] aluresultM, writedataM, pcplus4M;
    logic [4:0]  rdM;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // clock / reset
    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .regwriteE(regwriteE), .resultsrcE(resultsrcE), .memwriteE(memwriteE),
        .branchE(branchE), .jumpE(jumpE), .alucontrolE(alucontrolE),
        .alusrcE(alusrcE), .rd1E(rd1E), .rd2E(rd2E), .pcE(pcE),
        .immextE(immextE), .pcplus4E(pcplus4E), .rdE(rdE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
        .pcsrcE(pcsrcE), .pctargetE(pctargetE),
        .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
        .aluresultM(aluresultM), .writedataM(writedataM), .rdM(rdM),
        .pcplus4M(pcplus4M)
    );

    // driver tasks
    task automatic set_defaults();
        rst = 1'b0; regwriteE = 1'b0; resultsrcE = 2'b00; memwriteE = 1'b0;
        branchE = 1'b0; jumpE = 1'b0; alucontrolE = 3'b000; alusrcE = 1'b0;
        rd1E = 32'h0; rd2E = 32'h0; pcE = 32'h0; immextE = 32'h0;
        pcplus4E = 32'h4; rdE = 5'h0; forwardAE = 2'b00; forwardBE = 2'b00;
        resultW = 32'h0;
    endtask

    task automatic issue(input string name, input logic [31:0] exp_alu,
                         input logic [31:0] exp_wd, input logic exp_pcsrc,
                         input logic [31:0] exp_tgt);
        logic [W-1:0] e;
        #1;
        checks++;
        if (pcsrcE !== exp_pcsrc) begin
            failures++;
            $display("FAIL %s pcsrcE got=%b exp=%b", name, pcsrcE, exp_pcsrc);
        end
        checks++;
        if (pctargetE !== exp_tgt) begin
            failures++;
            $display("FAIL %s pctargetE got=%h exp=%h", name, pctargetE, exp_tgt);
        end
        if (rst)
            e = '0;
        else
            e = {regwriteE, resultsrcE, memwriteE, exp_alu, exp_wd, rdE, pcplus4E};
        exp_q.push_back(e);
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        logic [W-1:0] got, exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {regwriteM, resultsrcM, memwriteM, aluresultM, writedataM, rdM, pcplus4M};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL exmem got rw=%b rs=%b mw=%b alu=%h wd=%h rd=%0d p4=%h exp rw=%b rs=%b mw=%b alu=%h wd=%h rd=%0d p4=%h",
                         got[104], got[103:102], got[101], got[100:69], got[68:37], got[36:32], got[31:0],
                         exp[104], exp[103:102], exp[101], exp[100:69], exp[68:37], exp[36:32], exp[31:0]);
            end
        end
    end

    initial begin
        set_defaults();
        rst = 1'b1;

        // reset with a live store and a taken branch on the inputs
        @(negedge clk); set_defaults(); rst = 1'b1; memwriteE = 1'b1; regwriteE = 1'b1;
        rdE = 5'd9; pcplus4E = 32'h84; branchE = 1'b1; alucontrolE = 3'b001;
        rd1E = 32'h2; rd2E = 32'h2; pcE = 32'h80; immextE = 32'h8;
        issue("reset", 32'h0, 32'h0, 1'b1, 32'h88);

        // add 5+7 -> x3
        @(negedge clk); set_defaults(); rd1E = 32'd5; rd2E = 32'd7; rdE = 5'd3; regwriteE = 1'b1;
        issue("add", 32'd12, 32'd7, 1'b0, 32'h0);

        // signed slt -1 < 1
        @(negedge clk); set_defaults(); rd1E = 32'hFFFFFFFF; immextE = 32'h1; alusrcE = 1'b1;
        alucontrolE = 3'b101;
        issue("slt_neg", 32'h1, 32'h0, 1'b0, 32'h1);

        // add wraps -1 + 1 = 0
        @(negedge clk); set_defaults(); rd1E = 32'hFFFFFFFF; immextE = 32'h1; alusrcE = 1'b1;
        issue("add_wrap", 32'h0, 32'h0, 1'b0, 32'h1);

        // beq taken, backward target
        @(negedge clk); set_defaults(); branchE = 1'b1; rd1E = 32'd9; rd2E = 32'd9;
        alucontrolE = 3'b001; pcE = 32'h100; immextE = 32'hFFFFFFF8; pcplus4E = 32'h104;
        issue("beq_taken", 32'h0, 32'd9, 1'b1, 32'hF8);

        // beq not taken
        @(negedge clk); set_defaults(); branchE = 1'b1; rd1E = 32'd9; rd2E = 32'd8;
        alucontrolE = 3'b001; pcE = 32'h100; immextE = 32'hFFFFFFF8; pcplus4E = 32'h104;
        issue("beq_not", 32'h1, 32'd8, 1'b0, 32'hF8);

        // produce aluresultM = 20 for the forwarding vectors
        @(negedge clk); set_defaults(); rd1E = 32'd20; rdE = 5'd5; regwriteE = 1'b1;
        issue("fwd_setup", 32'd20, 32'h0, 1'b0, 32'h0);

        // A from aluresultM, B from resultW
        @(negedge clk); set_defaults(); rd1E = 32'd1; rd2E = 32'd2; resultW = 32'd30;
        forwardAE = 2'b10; forwardBE = 2'b01;
`ifdef EX_FORWARD_EN
        issue("fwd_10_01", 32'd50, 32'd30, 1'b0, 32'h0);
`else
        issue("fwd_10_01", 32'd3, 32'd2, 1'b0, 32'h0);
`endif

        // A from resultW, B from aluresultM, subtract
        @(negedge clk); set_defaults(); rd1E = 32'd100; rd2E = 32'd200; resultW = 32'd7;
        forwardAE = 2'b01; forwardBE = 2'b10; alucontrolE = 3'b001;
`ifdef EX_FORWARD_EN
        issue("fwd_01_10", 32'hFFFFFFD5, 32'd50, 1'b0, 32'h0);
`else
        issue("fwd_01_10", 32'hFFFFFF9C, 32'd200, 1'b0, 32'h0);
`endif

        // select 11 falls back to register operands
        @(negedge clk); set_defaults(); rd1E = 32'd4; rd2E = 32'd6; resultW = 32'd99;
        forwardAE = 2'b11; forwardBE = 2'b11;
        issue("fwd_11", 32'd10, 32'd6, 1'b0, 32'h0);

        // logic ops and undefined codes
        @(negedge clk); set_defaults(); rd1E = 32'hF0F0; rd2E = 32'hFF00; alucontrolE = 3'b010;
        issue("and", 32'hF000, 32'hFF00, 1'b0, 32'h0);
        @(negedge clk); set_defaults(); rd1E = 32'hF0F0; rd2E = 32'hFF00; alucontrolE = 3'b011;
        issue("or", 32'hFFF0, 32'hFF00, 1'b0, 32'h0);
        @(negedge clk); set_defaults(); rd1E = 32'hF0F0; rd2E = 32'hFF00; alucontrolE = 3'b100;
        issue("op100", 32'h0, 32'hFF00, 1'b0, 32'h0);
        @(negedge clk); set_defaults(); rd1E = 32'hF0F0; rd2E = 32'hFF00; alucontrolE = 3'b110;
        issue("op110", 32'h0, 32'hFF00, 1'b0, 32'h0);
        @(negedge clk); set_defaults(); rd1E = 32'hF0F0; rd2E = 32'hFF00; alucontrolE = 3'b111;
        issue("op111", 32'h0, 32'hFF00, 1'b0, 32'h0);

        // sub wrap 0 - 1
        @(negedge clk); set_defaults(); rd2E = 32'd1; alucontrolE = 3'b001;
        issue("sub_wrap", 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0);

        // slt is signed: 5 < -3 is false
        @(negedge clk); set_defaults(); rd1E = 32'd5; rd2E = 32'hFFFFFFFD; alucontrolE = 3'b101;
        issue("slt_pos", 32'h0, 32'hFFFFFFFD, 1'b0, 32'h0);

        // store: immediate offset, data stays rs2
        @(negedge clk); set_defaults(); rd1E = 32'd10; rd2E = 32'd77; immextE = 32'd5;
        alusrcE = 1'b1; memwriteE = 1'b1; pcE = 32'h40; pcplus4E = 32'h44;
        issue("store", 32'd15, 32'd77, 1'b0, 32'h45);

        // branch taken via add wrapping to zero
        @(negedge clk); set_defaults(); branchE = 1'b1; rd1E = 32'd3; rd2E = 32'hFFFFFFFD;
        issue("beq_addzero", 32'h0, 32'hFFFFFFFD, 1'b1, 32'h0);

        // branch and jump together, zero false
        @(negedge clk); set_defaults(); branchE = 1'b1; jumpE = 1'b1; rd1E = 32'd1; rd2E = 32'd2;
        alucontrolE = 3'b001; pcE = 32'h300; immextE = 32'hFFFFFF00; pcplus4E = 32'h304;
        issue("br_jal", 32'hFFFFFFFF, 32'd2, 1'b1, 32'h200);

        // jal: link pc+4
        @(negedge clk); set_defaults(); jumpE = 1'b1; pcE = 32'h200; immextE = 32'h20;
        pcplus4E = 32'h204; resultsrcE = 2'b10; rdE = 5'd1; regwriteE = 1'b1;
        issue("jal", 32'h0, 32'h0, 1'b1, 32'h220);

        // reset kills an in-flight store
        @(negedge clk); set_defaults(); rst = 1'b1; memwriteE = 1'b1; regwriteE = 1'b1;
        rd1E = 32'd5; rd2E = 32'd6; rdE = 5'd4; pcE = 32'h10; immextE = 32'h4; pcplus4E = 32'h14;
        resultsrcE = 2'b01;
        issue("rst_store", 32'h0, 32'h0, 1'b0, 32'h14);

        // normal flow resumes after reset
        @(negedge clk); set_defaults(); rd1E = 32'd1; rd2E = 32'd1; rdE = 5'd31; regwriteE = 1'b1;
        resultsrcE = 2'b01;
        issue("post_rst", 32'd2, 32'd1, 1'b0, 32'h0);

        @(negedge clk); set_defaults();
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
